fib_seq_gen: RTL and testbench

Parametrised successor of the fixed 8-bit Fibonacci chip. On request it walks the sequence F(0)=0, F(1)=1, … up to F(n) for a runtime index n. Every term is streamed out over a valid/ready interface, and F(n) is reported as a result with a done pulse. The datapath width is parametrised, and wrap-around is detected and flagged per term rather than silently lost. It sits beside or replaces the existing chip as a reusable sequencer feeding downstream consumers.

---
 rtl/fib_pkg.sv | 13 +
 rtl/fib_seq_gen_if.sv | 27 ++
 rtl/fib_step.sv | 20 ++
 rtl/fib_seq_gen.sv | 97 +++++++++
 tb/tb_fib_seq_gen.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci sequencer.
package fib_pkg;

   typedef enum logic [1:0] {
      FIB_IDLE = 2'd0,
      FIB_RUN  = 2'd1,
      FIB_DONE = 2'd2
   } fib_state_e;

   localparam int FIB_F0 = 0;
   localparam int FIB_F1 = 1;

endpackage

// File: rtl/fib_seq_gen_if.sv
// Term stream: valid/ready handshake carrying one sequence term.
interface fib_seq_gen_if #(
   parameter int WIDTH   = 8,
   parameter int N_WIDTH = 4
);
   logic               term_valid;
   logic               term_ready;
   logic [WIDTH-1:0]   term_data;
   logic [N_WIDTH-1:0] term_idx;
   logic               term_ovf;

   modport master (
      output term_valid,
      input  term_ready,
      output term_data,
      output term_idx,
      output term_ovf
   );

   modport slave (
      input  term_valid,
      output term_ready,
      input  term_data,
      input  term_idx,
      input  term_ovf
   );
endinterface

// File: rtl/fib_step.sv
// One Fibonacci step: a+b with carry and sticky wrap propagation.
module fib_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             a_ovf,
   input  logic             b_ovf,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             ovf_out
);
   logic [WIDTH:0] sum_w;

   assign sum_w     = {1'b0, a} + {1'b0, b};
   assign sum       = sum_w[WIDTH-1:0];
   assign carry_out = sum_w[WIDTH];
   // a wrapped operand taints every later term
   assign ovf_out   = carry_out | a_ovf | b_ovf;
endmodule

// File: rtl/fib_seq_gen.sv
// Fibonacci sequencer: streams F(0)..F(n), reports F(n) with done.
module fib_seq_gen
   import fib_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int N_WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [N_WIDTH-1:0] n,
   output logic               start_ready,
   fib_seq_gen_if.master      term,
   output logic               done,
   output logic [WIDTH-1:0]   result,
   output logic               result_ovf
);
   localparam logic [1:0] IDLE = FIB_IDLE;
   localparam logic [1:0] RUN  = FIB_RUN;
   localparam logic [1:0] DONE = FIB_DONE;

   logic [1:0]         state;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               a_ovf;
   logic               b_ovf;
   logic [N_WIDTH-1:0] idx;
   logic [N_WIDTH-1:0] n_reg;
   logic [WIDTH-1:0]   nxt;
   logic               nxt_ovf;
   logic               nxt_carry;
   logic               hs;
   logic               last;

   fib_step #(.WIDTH(WIDTH)) u_step (
      .a         (a),
      .b         (b),
      .a_ovf     (a_ovf),
      .b_ovf     (b_ovf),
      .sum       (nxt),
      .carry_out (nxt_carry),
      .ovf_out   (nxt_ovf)
   );

   assign start_ready     = (state == IDLE);
   assign done            = (state == DONE);
   assign term.term_valid = (state == RUN);
   assign term.term_data  = a;
   assign term.term_idx   = idx;
   assign term.term_ovf   = a_ovf;

   assign hs   = term.term_valid & term.term_ready;
   assign last = (idx == n_reg);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         a          <= WIDTH'(FIB_F0);
         b          <= WIDTH'(FIB_F1);
         a_ovf      <= 1'b0;
         b_ovf      <= 1'b0;
         idx        <= '0;
         n_reg      <= '0;
         result     <= '0;
         result_ovf <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  n_reg <= n;
                  a     <= WIDTH'(FIB_F0);
                  b     <= WIDTH'(FIB_F1);
                  a_ovf <= 1'b0;
                  b_ovf <= 1'b0;
                  idx   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               if (hs && last) begin
                  result     <= a;
                  result_ovf <= a_ovf;
                  state      <= DONE;
               end else if (hs) begin
                  a     <= b;
                  a_ovf <= b_ovf;
                  b     <= nxt;
                  b_ovf <= nxt_ovf;
                  idx   <= idx + 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed bench for fib_seq_gen against a hand-computed term table.
`timescale 1ns/1ps
module tb_fib_seq_gen;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [3:0] n;
   logic       start_ready;
   logic       done;
   logic [7:0] result;
   logic       result_ovf;

   int n_cmp = 0;
   int n_err = 0;

   // F(i) mod 256; terms from index 14 on have wrapped
   int fib_tab [16] = '{0, 1, 1, 2, 3, 5, 8, 13,
                        21, 34, 55, 89, 144, 233, 121, 98};

   fib_seq_gen_if #(.WIDTH(8), .N_WIDTH(4)) tif ();

   fib_seq_gen #(.WIDTH(8), .N_WIDTH(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .n           (n),
      .start_ready (start_ready),
      .term        (tif),
      .done        (done),
      .result      (result),
      .result_ovf  (result_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got,
                        input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic run_seq(input int nn, input bit bp, input bit poke);
      int  got_n;
      int  held_d;
      int  held_i;
      bit  stalled;
      bit  seen_done;
      bit  rdy;
      got_n     = 0;
      stalled   = 0;
      seen_done = 0;
      held_d    = 0;
      held_i    = 0;
      @(negedge clk);
      start = 1'b1;
      n     = 4'(nn);
      @(negedge clk);
      start = 1'b0;
      check("srdy_after_acc", start_ready, 0);
      for (int k = 0; k < 200 && !seen_done; k++) begin
         if (k > 0) @(negedge clk);
         start = 1'b0;
         if (done) begin
            seen_done = 1;
            if (!bp) check("latency", k, nn + 1);
            check("term_count", got_n, nn + 1);
         end else begin
            if (stalled) begin
               check("hold_data", tif.term_data, held_d);
               check("hold_idx", tif.term_idx, held_i);
            end
            if (poke) check("srdy_busy", start_ready, 0);
            rdy = bp ? ((k % 3) == 0) : 1'b1;
            tif.term_ready = rdy;
            if (!tif.term_valid) begin
               check("valid_gap", tif.term_valid, 1);
            end else if (rdy) begin
               check("term_data", tif.term_data, fib_tab[got_n]);
               check("term_idx", tif.term_idx, got_n);
               check("term_ovf", tif.term_ovf, (got_n >= 14) ? 1 : 0);
               got_n++;
               stalled = 0;
            end else begin
               stalled = 1;
               held_d  = int'(tif.term_data);
               held_i  = int'(tif.term_idx);
            end
            if (poke && k == 2) begin
               start = 1'b1;
               n     = 4'd3;
            end
         end
      end
      if (!seen_done) check("done_timeout", 0, 1);
      check("result", result, fib_tab[nn]);
      check("result_ovf", result_ovf, (nn >= 14) ? 1 : 0);
      @(negedge clk);
      check("done_pulse", done, 0);
      check("srdy_idle", start_ready, 1);
      tif.term_ready = 1'b0;
   endtask

   initial begin
      bit saw_done;
      rst_n          = 1'b0;
      start          = 1'b0;
      n              = '0;
      tif.term_ready = 1'b0;
      #23;
      check("rst_srdy", start_ready, 1);
      check("rst_valid", tif.term_valid, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_data", tif.term_data, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_seq(10, 0, 0);
      run_seq(0, 0, 0);
      run_seq(13, 0, 0);
      run_seq(14, 0, 0);
      run_seq(15, 0, 0);
      run_seq(6, 1, 0);
      run_seq(5, 0, 1);
      run_seq(15, 0, 0);

      @(negedge clk);
      start = 1'b1;
      n     = 4'd10;
      @(negedge clk);
      start          = 1'b0;
      tif.term_ready = 1'b1;
      for (int k = 0; k < 50 && tif.term_idx != 4'd4; k++)
         @(negedge clk);
      check("reach_idx4", tif.term_idx, 4);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", tif.term_valid, 0);
      check("arst_srdy", start_ready, 1);
      check("arst_result", result, 0);
      check("arst_rovf", result_ovf, 0);
      check("arst_data", tif.term_data, 0);
      check("arst_idx", tif.term_idx, 0);
      saw_done = 0;
      repeat (2) begin
         @(negedge clk);
         saw_done |= done;
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         saw_done |= done;
      end
      check("arst_no_done", saw_done, 0);
      tif.term_ready = 1'b0;
      run_seq(3, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule
